serial_sub4: RTL

Bit-serial 4-bit full subtractor with borrow-in and borrow-out. It computes a − b − bin one bit per clock, LSB first, and exposes the per-bit borrow chain on shiftedborrow. It is the sequential counterpart of the combinational 4-bit adder in the 74-series logic library. It sits behind a start/done handshake so a controller can issue one subtraction at a time.

---
 rtl/serial_sub4_pkg.sv | 26 ++
 rtl/serial_sub4_if.sv | 40 ++++
 rtl/serial_sub4_full_sub1.sv | 37 +++
 rtl/serial_sub4.sv | 120 ++++++++++++
 4 files changed

// File: rtl/serial_sub4_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub4_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_t      : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width()  : bit-counter width for a given operand width
//   CNT_W        : counter width for the default 4-bit build
// ----------------------------------------------------------------------------
package serial_sub4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

    // A 1-bit counter is still needed when the width is small enough
    // that $clog2 would return 0.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/serial_sub4_if.sv
// ----------------------------------------------------------------------------
// serial_sub4_if
// Start/done handshake and operand/result bus of serial_sub4.
//   start, a, b, bin    : request and operands (controller -> block)
//   mode                : 1 = subtract, 0 = add; present only when
//                         SERIAL_SUB4_ADD_MODE_EN is defined
//   busy, done          : status (block -> controller)
//   diff, bout,
//   shiftedborrow       : registered results (block -> controller)
// Modports: master = controller side, slave = serial_sub4 side.
// ----------------------------------------------------------------------------
interface serial_sub4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
`ifdef SERIAL_SUB4_ADD_MODE_EN
    logic             mode;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [WIDTH:0]   shiftedborrow;

`ifdef SERIAL_SUB4_ADD_MODE_EN
    modport master (output start, a, b, bin, mode,
                    input  busy, done, diff, bout, shiftedborrow);
    modport slave  (input  start, a, b, bin, mode,
                    output busy, done, diff, bout, shiftedborrow);
`else
    modport master (output start, a, b, bin,
                    input  busy, done, diff, bout, shiftedborrow);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, bout, shiftedborrow);
`endif

endinterface

// File: rtl/serial_sub4_full_sub1.sv
// ----------------------------------------------------------------------------
// full_sub1
// Combinational 1-bit full subtractor: d = x - y - bi, borrow out bo.
// With SERIAL_SUB4_ADD_MODE_EN defined, an extra mode input selects
// subtraction (mode=1) or addition (mode=0, bi/bo act as carry).
//   x, y  : operand bits
//   bi    : borrow (or carry) in
//   mode  : operation select (optional)
//   d     : result bit
//   bo    : borrow (or carry) out
// ----------------------------------------------------------------------------
module full_sub1 (
    input  logic x,
    input  logic y,
    input  logic bi,
`ifdef SERIAL_SUB4_ADD_MODE_EN
    input  logic mode,
`endif
    output logic d,
    output logic bo
);

    logic borrow;

    // Sum and difference bits are identical; only the chain term differs.
    assign d      = x ^ y ^ bi;
    assign borrow = (~x & y) | (~(x ^ y) & bi);

`ifdef SERIAL_SUB4_ADD_MODE_EN
    logic carry;
    assign carry = (x & y) | (x & bi) | (y & bi);
    assign bo    = mode ? borrow : carry;
`else
    assign bo    = borrow;
`endif

endmodule

// File: rtl/serial_sub4.sv
// ----------------------------------------------------------------------------
// serial_sub4
// Bit-serial WIDTH-bit full subtractor, LSB first, one bit per clock,
// behind a start/done handshake. Computes a - b - bin and exposes the
// borrow chain ([0]=bin, [i+1]=borrow out of bit i).
// Optional feature macro: SERIAL_SUB4_ADD_MODE_EN (adds mode: 0 = add).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_sub4_if.slave (start, a, b, bin, [mode],
//            busy, done, diff, bout, shiftedborrow)
// ----------------------------------------------------------------------------
module serial_sub4
    import serial_sub4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_sub4_if.slave    bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_diff;
    // Borrow chain shifts in from the top: the current borrow is always
    // work_br[WIDTH], and after WIDTH shifts bin lands in bit 0.
    logic [WIDTH:0]   work_br;
`ifdef SERIAL_SUB4_ADD_MODE_EN
    logic             mode_r;
`endif

    logic d_bit;
    logic br_next;
    logic last_bit;

    // Operands shift right so the bit being processed is always bit 0.
    full_sub1 u_bit (
        .x    (a_r[0]),
        .y    (b_r[0]),
        .bi   (work_br[WIDTH]),
`ifdef SERIAL_SUB4_ADD_MODE_EN
        .mode (mode_r),
`endif
        .d    (d_bit),
        .bo   (br_next)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // The working registers are few and small, so all of them are reset
    // to give a fully defined state after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            a_r               <= '0;
            b_r               <= '0;
            work_diff         <= '0;
            work_br           <= '0;
`ifdef SERIAL_SUB4_ADD_MODE_EN
            mode_r            <= 1'b1;
`endif
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.diff          <= '0;
            bus.bout          <= 1'b0;
            bus.shiftedborrow <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= SHIFT;
                        bus.busy  <= 1'b1;
                        cnt       <= '0;
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        work_diff <= '0;
                        work_br   <= {bus.bin, WIDTH'(0)};
`ifdef SERIAL_SUB4_ADD_MODE_EN
                        mode_r    <= bus.mode;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    a_r       <= a_r >> 1;
                    b_r       <= b_r >> 1;
                    work_diff <= {d_bit, work_diff[WIDTH-1:1]};
                    work_br   <= {br_next, work_br[WIDTH:1]};
                    cnt       <= cnt + CW'(1);
                    // Results are published straight from the final shift so
                    // they are visible during the DONE cycle itself.
                    if (last_bit) begin
                        state             <= DONE;
                        bus.busy          <= 1'b0;
                        bus.done          <= 1'b1;
                        bus.diff          <= {d_bit, work_diff[WIDTH-1:1]};
                        bus.bout          <= br_next;
                        bus.shiftedborrow <= {br_next, work_br[WIDTH:1]};
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
